// File: rtl/spi_reg_bank.sv
// rtl/spi_reg_bank.sv - SPI mode-0 peripheral driving a bank of control registers
// Optional feature macro: SPI_REG_BANK_READ_EN (register readback on cipo)
module spi_reg_bank #(
  parameter int ADDR_W   = 7,
  parameter int DATA_W   = 8,
  parameter int NUM_REGS = 5
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       sclk,
  input  logic                       copi,
  input  logic                       cs_n,
  output logic                       cipo,
  output logic [NUM_REGS*DATA_W-1:0] regs_o,
  output logic                       wr_stb,
  output logic [ADDR_W-1:0]          wr_addr,
  output logic                       frame_err
);

  localparam int FRAME_W = 1 + ADDR_W + DATA_W;
  localparam int HDR_W   = 1 + ADDR_W;
  localparam int CNT_W   = $clog2(FRAME_W + 2);
  localparam int AW1     = ADDR_W + 1;

  localparam logic [CNT_W-1:0] CNT_HDR  = CNT_W'(HDR_W);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_W);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(FRAME_W + 1);
  localparam logic [AW1-1:0]   ADDR_LIM = AW1'(NUM_REGS);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_HDR    = 2'd1;
  localparam logic [1:0] ST_DATA   = 2'd2;
  localparam logic [1:0] ST_COMMIT = 2'd3;

  logic r_sclk_s1, r_sclk_s2, r_sclk_d;
  logic r_copi_s1, r_copi_s2;
  logic r_cs_s1, r_cs_s2, r_cs_d;

  logic [1:0]         r_state;
  logic [FRAME_W-1:0] r_shreg;
  logic [CNT_W-1:0]   r_bitcnt;
  logic [DATA_W-1:0]  r_regs [NUM_REGS];

  logic               w_sclk_rise, w_cs_fall, w_cs_rise;
  logic [FRAME_W-1:0] w_shreg_next;
  logic [CNT_W-1:0]   w_cnt_next;
  logic               w_hdr_last;
  logic               w_c_rw, w_c_ok, w_wr_en;
  logic [ADDR_W-1:0]  w_c_addr;
  logic [DATA_W-1:0]  w_c_data;

  assign w_sclk_rise  = r_sclk_s2 & ~r_sclk_d;
  assign w_cs_fall    = ~r_cs_s2 & r_cs_d;
  assign w_cs_rise    = r_cs_s2 & ~r_cs_d;
  assign w_shreg_next = {r_shreg[FRAME_W-2:0], r_copi_s2};
  assign w_cnt_next   = (r_bitcnt == CNT_SAT) ? r_bitcnt : r_bitcnt + 1'b1;
  assign w_hdr_last   = (w_cnt_next == CNT_HDR);

  // Completed-frame fields, valid while the FSM sits in COMMIT
  assign w_c_rw   = r_shreg[FRAME_W-1];
  assign w_c_addr = r_shreg[DATA_W +: ADDR_W];
  assign w_c_data = r_shreg[DATA_W-1:0];
  assign w_c_ok   = (r_bitcnt == CNT_FULL) && ({1'b0, w_c_addr} < ADDR_LIM);
  assign w_wr_en  = (r_state == ST_COMMIT) && w_c_ok && w_c_rw;

  // Two-flop synchronisers plus a third copy of sclk/cs_n for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sclk_s1 <= 1'b0; r_sclk_s2 <= 1'b0; r_sclk_d <= 1'b0;
      r_copi_s1 <= 1'b0; r_copi_s2 <= 1'b0;
      r_cs_s1   <= 1'b1; r_cs_s2   <= 1'b1; r_cs_d   <= 1'b1;
    end else begin
      r_sclk_s1 <= sclk;  r_sclk_s2 <= r_sclk_s1; r_sclk_d <= r_sclk_s2;
      r_copi_s1 <= copi;  r_copi_s2 <= r_copi_s1;
      r_cs_s1   <= cs_n;  r_cs_s2   <= r_cs_s1;   r_cs_d   <= r_cs_s2;
    end
  end

  // Frame FSM: shift on sclk rise first, then a cs_n rise closes the frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_shreg   <= '0;
      r_bitcnt  <= '0;
      wr_stb    <= 1'b0;
      wr_addr   <= '0;
      frame_err <= 1'b0;
    end else begin
      wr_stb    <= 1'b0;
      frame_err <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_cs_fall) begin
            r_state  <= ST_HDR;
            r_bitcnt <= '0;
            r_shreg  <= '0;
          end
        end
        ST_HDR, ST_DATA: begin
          if (w_sclk_rise) begin
            r_shreg  <= w_shreg_next;
            r_bitcnt <= w_cnt_next;
            if (r_state == ST_HDR && w_hdr_last) r_state <= ST_DATA;
          end
          if (w_cs_rise) r_state <= ST_COMMIT;
        end
        default: begin
          if (w_wr_en) begin
            wr_stb  <= 1'b1;
            wr_addr <= w_c_addr;
          end else if (!w_c_ok) begin
            frame_err <= 1'b1;
          end
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Register bank: only an accepted write frame changes contents
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else if (w_wr_en) begin
      for (int i = 0; i < NUM_REGS; i++)
        if (w_c_addr == ADDR_W'(i)) r_regs[i] <= w_c_data;
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs_o
    assign regs_o[g*DATA_W +: DATA_W] = r_regs[g];
  end

`ifdef SPI_REG_BANK_READ_EN
  logic              w_sclk_fall, w_h_rw, w_hdr_done;
  logic [ADDR_W-1:0] w_h_addr;
  logic [DATA_W-1:0] w_rd_data;
  logic [DATA_W-1:0] r_txreg;
  logic              r_cipo;

  assign w_sclk_fall = ~r_sclk_s2 & r_sclk_d;
  assign w_h_rw      = w_shreg_next[ADDR_W];
  assign w_h_addr    = w_shreg_next[ADDR_W-1:0];
  assign w_hdr_done  = (r_state == ST_HDR) && w_sclk_rise && w_hdr_last;

  // Readback mux; unmapped addresses read as zero
  always_comb begin
    w_rd_data = '0;
    for (int i = 0; i < NUM_REGS; i++)
      if (w_h_addr == ADDR_W'(i)) w_rd_data = r_regs[i];
  end

  // Load txreg at end of header, then present MSB first on each sclk fall
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_txreg <= '0;
      r_cipo  <= 1'b0;
    end else if (w_hdr_done) begin
      r_txreg <= w_h_rw ? '0 : w_rd_data;
      r_cipo  <= 1'b0;
    end else if (r_state == ST_DATA) begin
      if (w_sclk_fall) begin
        r_cipo  <= r_txreg[DATA_W-1];
        r_txreg <= {r_txreg[DATA_W-2:0], 1'b0};
      end
    end else begin
      r_cipo <= 1'b0;
    end
  end

  assign cipo = r_cipo;
`else
  assign cipo = 1'b0;
`endif

endmodule

// File: tb/tb_spi_reg_bank.sv
// tb/tb_spi_reg_bank.sv - self-checking bench for spi_reg_bank (default and swept parameters)
`timescale 1ns/1ps
module tb_spi_reg_bank;

`ifdef SPI_REG_BANK_READ_EN
  localparam bit READ_EN = 1'b1;
`else
  localparam bit READ_EN = 1'b0;
`endif

  logic         clk = 1'b0, rst_n = 1'b0;
  logic         sclk = 1'b0, copi = 1'b0, cs0_n = 1'b1, cs1_n = 1'b1;
  logic         cipo0, cipo1, wr_stb0, wr_stb1, frame_err0, frame_err1;
  logic [39:0]  regs0;
  logic [255:0] regs1;
  logic [6:0]   wr_addr0;
  logic [3:0]   wr_addr1;

  int checks = 0, errors = 0;
  int stb0_n = 0, err0_n = 0, stb1_n = 0, err1_n = 0;
  logic [7:0]  m0 [5];
  logic [15:0] m1 [16];

  always #5 clk = ~clk;

  spi_reg_bank u_dut0 (
    .clk(clk), .rst_n(rst_n), .sclk(sclk), .copi(copi), .cs_n(cs0_n), .cipo(cipo0),
    .regs_o(regs0), .wr_stb(wr_stb0), .wr_addr(wr_addr0), .frame_err(frame_err0)
  );

  spi_reg_bank #(.ADDR_W(4), .DATA_W(16), .NUM_REGS(16)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .sclk(sclk), .copi(copi), .cs_n(cs1_n), .cipo(cipo1),
    .regs_o(regs1), .wr_stb(wr_stb1), .wr_addr(wr_addr1), .frame_err(frame_err1)
  );

  always @(negedge clk) begin
    if (wr_stb0)    stb0_n++;
    if (frame_err0) err0_n++;
    if (wr_stb1)    stb1_n++;
    if (frame_err1) err1_n++;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [39:0] exp0();
    logic [39:0] r;
    for (int i = 0; i < 5; i++) r[i*8 +: 8] = m0[i];
    return r;
  endfunction

  function automatic logic [255:0] exp1();
    logic [255:0] r;
    for (int i = 0; i < 16; i++) r[i*16 +: 16] = m1[i];
    return r;
  endfunction

  task automatic shift_bits(input int which, input int nbits, input logic [31:0] frame,
                            output logic [31:0] rx);
    rx = '0;
    for (int i = nbits - 1; i >= 0; i--) begin
      copi = frame[i];
      #40;
      rx[i] = (which == 1) ? cipo1 : cipo0;
      sclk = 1'b1;
      #40;
      sclk = 1'b0;
    end
  endtask

  task automatic send_frame(input int which, input int nbits, input logic [31:0] frame,
                            output logic [31:0] rx);
    @(negedge clk);
    if (which == 1) cs1_n = 1'b0; else cs0_n = 1'b0;
    #40;
    shift_bits(which, nbits, frame, rx);
    #40;
    cs0_n = 1'b1;
    cs1_n = 1'b1;
    copi  = 1'b0;
    #100;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 5; i++)  m0[i] = '0;
    for (int i = 0; i < 16; i++) m1[i] = '0;
    repeat (3) @(negedge clk);
    checks++; if (regs0 !== 40'h0) begin errors++; $display("FAIL reset_regs0: got %h expected 0", regs0); end
    checks++; if (regs1 !== 256'h0) begin errors++; $display("FAIL reset_regs1: got %h expected 0", regs1); end
    checks++; if ({wr_stb0, frame_err0, cipo0} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b expected 000", {wr_stb0, frame_err0, cipo0}); end
    checks++; if (wr_addr0 !== 7'h0) begin errors++; $display("FAIL reset_wr_addr: got %h expected 0", wr_addr0); end
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_write();
    int s, e;
    logic [31:0] rx;
    s = stb0_n; e = err0_n;
    send_frame(0, 16, 32'h80A5, rx);
    m0[0] = 8'hA5;
    checks++; if (regs0 !== exp0()) begin errors++; $display("FAIL write_regs: got %h expected %h", regs0, exp0()); end
    checks++; if (stb0_n - s !== 1) begin errors++; $display("FAIL write_stb: got %0d expected 1", stb0_n - s); end
    checks++; if (wr_addr0 !== 7'd0) begin errors++; $display("FAIL write_addr: got %h expected 0", wr_addr0); end
    checks++; if (err0_n - e !== 0) begin errors++; $display("FAIL write_err: got %0d expected 0", err0_n - e); end
  endtask

  task automatic test_readback();
    int s, e;
    logic [31:0] rx;
    s = stb0_n; e = err0_n;
    send_frame(0, 16, 32'h843C, rx);
    m0[4] = 8'h3C;
    send_frame(0, 16, 32'h0400, rx);
    checks++; if (rx[7:0] !== (READ_EN ? 8'h3C : 8'h00)) begin errors++; $display("FAIL readback_cipo: got %h expected %h", rx[7:0], READ_EN ? 8'h3C : 8'h00); end
    checks++; if (regs0 !== exp0()) begin errors++; $display("FAIL readback_regs: got %h expected %h", regs0, exp0()); end
    checks++; if (stb0_n - s !== 1) begin errors++; $display("FAIL readback_stb: got %0d expected 1", stb0_n - s); end
    checks++; if (wr_addr0 !== 7'd4) begin errors++; $display("FAIL readback_wr_addr: got %h expected 4", wr_addr0); end
    checks++; if (err0_n - e !== 0) begin errors++; $display("FAIL readback_err: got %0d expected 0", err0_n - e); end
  endtask

  task automatic test_bad_len();
    int s, e;
    logic [31:0] rx;
    s = stb0_n; e = err0_n;
    send_frame(0, 15, 32'h40AA, rx);
    checks++; if (err0_n - e !== 1) begin errors++; $display("FAIL short_err: got %0d expected 1", err0_n - e); end
    send_frame(0, 17, 32'h102EF, rx);
    checks++; if (err0_n - e !== 2) begin errors++; $display("FAIL long_err: got %0d expected 2", err0_n - e); end
    checks++; if (regs0 !== exp0()) begin errors++; $display("FAIL bad_len_regs: got %h expected %h", regs0, exp0()); end
    checks++; if (stb0_n - s !== 0) begin errors++; $display("FAIL bad_len_stb: got %0d expected 0", stb0_n - s); end
  endtask

  task automatic test_out_of_range();
    int s, e;
    logic [31:0] rx;
    s = stb0_n; e = err0_n;
    send_frame(0, 16, 32'h85FF, rx);
    checks++; if (regs0 !== exp0()) begin errors++; $display("FAIL oor_regs: got %h expected %h", regs0, exp0()); end
    checks++; if (err0_n - e !== 1) begin errors++; $display("FAIL oor_err: got %0d expected 1", err0_n - e); end
    checks++; if (stb0_n - s !== 0) begin errors++; $display("FAIL oor_stb: got %0d expected 0", stb0_n - s); end
  endtask

  task automatic test_reset_mid_frame();
    int s, e;
    logic [31:0] rx;
    s = stb0_n; e = err0_n;
    @(negedge clk);
    cs0_n = 1'b0;
    #40;
    shift_bits(0, 10, 32'h82C3 >> 6, rx);
    rst_n = 1'b0;
    #20;
    for (int i = 0; i < 5; i++)  m0[i] = '0;
    for (int i = 0; i < 16; i++) m1[i] = '0;
    checks++; if (regs0 !== 40'h0) begin errors++; $display("FAIL midrst_regs: got %h expected 0", regs0); end
    checks++; if ({wr_stb0, frame_err0, cipo0} !== 3'b000) begin errors++; $display("FAIL midrst_flags: got %b expected 000", {wr_stb0, frame_err0, cipo0}); end
    checks++; if (wr_addr0 !== 7'h0) begin errors++; $display("FAIL midrst_wr_addr: got %h expected 0", wr_addr0); end
    cs0_n = 1'b1;
    copi  = 1'b0;
    #40;
    rst_n = 1'b1;
    #80;
    checks++; if (stb0_n - s !== 0 || err0_n - e !== 0) begin errors++; $display("FAIL midrst_pulses: got stb %0d err %0d expected 0 0", stb0_n - s, err0_n - e); end
    send_frame(0, 16, 32'h8211, rx);
    m0[2] = 8'h11;
    checks++; if (regs0 !== exp0()) begin errors++; $display("FAIL midrst_next_regs: got %h expected %h", regs0, exp0()); end
    checks++; if (wr_addr0 !== 7'd2) begin errors++; $display("FAIL midrst_next_addr: got %h expected 2", wr_addr0); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      int len, s, e;
      bit exp_err, exp_stb;
      logic rw;
      logic [6:0] addr;
      logic [7:0] data, exp_rx;
      logic [31:0] f, rx;
      len  = ($urandom_range(0, 9) == 0) ? (($urandom_range(0, 1) == 1) ? 15 : 17) : 16;
      rw   = 1'($urandom_range(0, 1));
      addr = 7'($urandom_range(0, 7));
      data = 8'($urandom);
      f = {16'h0, rw, addr, data};
      if (len == 15) f = f >> 1;
      if (len == 17) f = (f << 1) | 32'h1;
      s = stb0_n; e = err0_n;
      exp_rx = (READ_EN && addr < 5) ? m0[addr[2:0]] : 8'h00;
      send_frame(0, len, f, rx);
      exp_err = (len != 16) || (addr >= 5);
      exp_stb = !exp_err && rw;
      if (exp_stb) m0[addr[2:0]] = data;
      checks++; if (regs0 !== exp0()) begin errors++; $display("FAIL rand_regs[%0d]: got %h expected %h", n, regs0, exp0()); end
      checks++; if (stb0_n - s !== int'(exp_stb) || err0_n - e !== int'(exp_err)) begin errors++; $display("FAIL rand_pulses[%0d]: got stb %0d err %0d expected %0d %0d", n, stb0_n - s, err0_n - e, exp_stb, exp_err); end
      if (exp_stb) begin
        checks++; if (wr_addr0 !== addr) begin errors++; $display("FAIL rand_wr_addr[%0d]: got %h expected %h", n, wr_addr0, addr); end
      end
      if (len == 16 && !rw) begin
        checks++; if (rx[7:0] !== exp_rx) begin errors++; $display("FAIL rand_cipo[%0d]: got %h expected %h", n, rx[7:0], exp_rx); end
      end
    end
  endtask

  task automatic test_sweep();
    int s, e;
    logic [31:0] rx;
    logic [3:0] a;
    logic [15:0] d;
    s = stb1_n; e = err1_n;
    send_frame(1, 21, 32'h1FBEEF, rx);
    m1[15] = 16'hBEEF;
    checks++; if (regs1 !== exp1()) begin errors++; $display("FAIL sweep_regs: got %h expected %h", regs1, exp1()); end
    checks++; if (stb1_n - s !== 1 || err1_n - e !== 0) begin errors++; $display("FAIL sweep_pulses: got stb %0d err %0d expected 1 0", stb1_n - s, err1_n - e); end
    checks++; if (wr_addr1 !== 4'hF) begin errors++; $display("FAIL sweep_wr_addr: got %h expected f", wr_addr1); end
    send_frame(1, 21, 32'h0F0000, rx);
    checks++; if (rx[15:0] !== (READ_EN ? 16'hBEEF : 16'h0)) begin errors++; $display("FAIL sweep_cipo: got %h expected %h", rx[15:0], READ_EN ? 16'hBEEF : 16'h0); end
    for (int n = 0; n < 8; n++) begin
      a = 4'($urandom);
      d = 16'($urandom);
      send_frame(1, 21, {11'h0, 1'b1, a, d}, rx);
      m1[a] = d;
      a = 4'($urandom);
      send_frame(1, 21, {11'h0, 1'b0, a, 16'h0}, rx);
      checks++; if (rx[15:0] !== (READ_EN ? m1[a] : 16'h0)) begin errors++; $display("FAIL sweep_rand_cipo[%0d]: got %h expected %h", n, rx[15:0], READ_EN ? m1[a] : 16'h0); end
    end
    checks++; if (regs1 !== exp1()) begin errors++; $display("FAIL sweep_rand_regs: got %h expected %h", regs1, exp1()); end
    checks++; if (regs0 !== exp0()) begin errors++; $display("FAIL sweep_isolation: got %h expected %h", regs0, exp0()); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_readback();
    test_bad_len();
    test_out_of_range();
    test_reset_mid_frame();
    test_random();
    test_sweep();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
